clk_period_meter: RTL

Measures the period of a slow, divided clock, such as the `clk_div` output of the selectable-tap clock divider, in system-clock cycles. It reports the divider tap that produced the measured period.
- It is the receive-side companion to the divider: the divider turns `sel` into a tap, and this block recovers `sel` from the waveform.
- It is used on-board and in benches to self-check divider settings and to drive a seven-segment/LED readout of the current rate.

---
 rtl/clk_period_meter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period of a slow clock-like signal in clk
// cycles and recovers the divider tap (sel) that produced it.
//
// Ports:
//   clk       system clock, rising edge
//   BTN0      synchronous active-high reset
//   sig_in    measured signal, asynchronous to clk
//   period    clk cycles between the last two rising edges of sig_in
//   sel_est   MSB index of period minus 1, saturated to 0..31
//   pow2      period is an exact power of two, at least 2
//   valid     period/sel_est/pow2 hold a real measurement
//   locked    last two measured periods were equal
//   timeout   sticky lost-signal flag, cleared by the next rising edge
//   edge_cnt  live count of cycles since the last rising edge
//
// Build option: define CLK_PERIOD_METER_LOCK_EN to build the old-period
// comparator and the locked flag; otherwise locked is tied to 0.

module clk_period_meter #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 32'd100_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             BTN0,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [4:0]       sel_est,
  output logic             pow2,
  output logic             valid,
  output logic             locked,
  output logic             timeout,
  output logic [CNT_W-1:0] edge_cnt
);

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO    = CNT_W'(2);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_TRACK
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   synced;
  logic                   rise;
  logic                   cnt_hit;
  int unsigned            msb_idx;

`ifdef CLK_PERIOD_METER_LOCK_EN
  logic lock_q;
  assign locked = lock_q;
`else
  assign locked = 1'b0;
`endif

  assign synced  = sync_q[SYNC_STAGES-1];
  assign rise    = synced & ~prev_q;
  assign cnt_hit = (edge_cnt == TO_CNT);

  always_ff @(posedge clk) begin
    if (BTN0) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      edge_cnt <= '0;
      period   <= '0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
      state    <= S_IDLE;
`ifdef CLK_PERIOD_METER_LOCK_EN
      lock_q   <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= synced;

      // Saturating counter: a stuck-low input must not wrap and fake a period.
      if (rise)
        edge_cnt <= ONE;
      else if (edge_cnt != '1)
        edge_cnt <= edge_cnt + ONE;

      // rise is tested before cnt_hit so a coincident edge records a period.
      case (state)
        S_IDLE: begin
          if (rise) begin
            timeout <= 1'b0;
            state   <= S_ARM;
          end else if (cnt_hit) begin
            timeout <= 1'b1;
          end
        end
        S_ARM: begin
          if (rise) begin
            period  <= edge_cnt;
            valid   <= 1'b1;
            timeout <= 1'b0;
            state   <= S_TRACK;
          end else if (cnt_hit) begin
            valid   <= 1'b0;
            timeout <= 1'b1;
            state   <= S_IDLE;
`ifdef CLK_PERIOD_METER_LOCK_EN
            lock_q  <= 1'b0;
`endif
          end
        end
        S_TRACK: begin
          if (rise) begin
            period  <= edge_cnt;
            timeout <= 1'b0;
`ifdef CLK_PERIOD_METER_LOCK_EN
            lock_q  <= (edge_cnt == period);
`endif
          end else if (cnt_hit) begin
            valid   <= 1'b0;
            timeout <= 1'b1;
            state   <= S_IDLE;
`ifdef CLK_PERIOD_METER_LOCK_EN
            lock_q  <= 1'b0;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Periods 0 and 1 have no meaningful tap and decode to sel_est = 0.
  always_comb begin
    msb_idx = 0;
    for (int unsigned i = 1; i < CNT_W; i++)
      if (period[i]) msb_idx = i;
    if (msb_idx == 0)
      sel_est = '0;
    else if (msb_idx > 32)
      sel_est = 5'd31;
    else
      sel_est = 5'(msb_idx - 1);
  end

  assign pow2 = (period >= TWO) && ((period & (period - ONE)) == '0);

endmodule
